// File: rtl/sysx_pkg.sv
// rtl/sysx_pkg.sv - sysX pipe phase encoding, byte-lane mapping and bus constants
package sysx_pkg;

  typedef enum logic [2:0] {
    sPipeIdle     = 3'd0,
    sPipeBegin    = 3'd1,
    sPipeLowLow   = 3'd2,
    sPipeLow      = 3'd3,
    sPipeHigh     = 3'd4,
    sPipeHighHigh = 3'd5,
    sPipeEnd      = 3'd6,
    sPipeInvalid  = 3'd7
  } pipePhase_t;

  localparam logic [7:0] SYSX_STATUS_OK   = 8'h00;
  localparam logic [1:0] SYSX_SELECT_NONE = 2'd0;

  function automatic logic isDataPhase(input pipePhase_t phase);
    return (phase >= sPipeLowLow) && (phase <= sPipeHighHigh);
  endfunction

  // The bus numbers bits MSB-first, so wire lane [24:31] is numeric bits [7:0] here.
  function automatic logic [4:0] laneBase(input pipePhase_t phase);
    case (phase)
      sPipeLowLow: return 5'd0;
      sPipeLow:    return 5'd8;
      sPipeHigh:   return 5'd16;
      default:     return 5'd24;
    endcase
  endfunction

endpackage

// File: rtl/sysx_bus_clockgen.sv
// rtl/sysx_bus_clockgen.sv - per-phase counter: phase strobes and bus clock level
module sysx_bus_clockgen #(
  parameter int CLOCK_DIV = 2
) (
  input  logic iClock,
  input  logic iReset,
  input  logic iActive,
  output logic oPhaseStart,
  output logic oSample,
  output logic oPhaseEnd,
  output logic oBusClock
);

  localparam int PHASE_LEN = 2 * CLOCK_DIV;
  localparam int CW = (PHASE_LEN > 2) ? $clog2(PHASE_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHASE_LEN - 1);
  localparam logic [CW-1:0] HALF = CW'(CLOCK_DIV);

  logic [CW-1:0] count;

  // Held at zero while idle so the first Begin cycle always starts the phase.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      count <= '0;
    end else if (!iActive || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign oPhaseStart = iActive && (count == '0);
  assign oSample     = iActive && (count == HALF);
  assign oPhaseEnd   = iActive && (count == LAST);
  assign oBusClock   = iActive && (count >= HALF);

endmodule

// File: rtl/sysx_pipe_scheduler.sv
// rtl/sysx_pipe_scheduler.sv - round-robin sysX bus scheduler for requesters A and B
// SYSX_SCHED_STATUS_EN: End-phase MISO byte is a slave status; nonzero flags oRespError.
module sysx_pipe_scheduler
  import sysx_pkg::*;
#(
  parameter int CLOCK_DIV = 2
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iReqValidA,
  input  logic [1:0]  iReqSelectA,
  input  logic [7:0]  iReqCmdA,
  input  logic [31:0] iReqDataA,
  output logic        oReqReadyA,
  input  logic        iReqValidB,
  input  logic [1:0]  iReqSelectB,
  input  logic [7:0]  iReqCmdB,
  input  logic [31:0] iReqDataB,
  output logic        oReqReadyB,
  output logic        oRespValid,
  output logic        oRespId,
  output logic [31:0] oRespData,
  output logic        oRespError,
  output logic [7:0]  oBusMOSI,
  input  logic [7:0]  iBusMISO,
  output logic        oBusClock,
  output logic [1:0]  oBusSelect
);

  pipePhase_t  phase, nextPhase;
  logic        lastGrantB, curId;
  logic [1:0]  curSel, winSel;
  logic [7:0]  curCmd;
  logic [31:0] curData, collected;
  logic        busActive, accept, grantA, grantB;
  logic        phaseStart, sample, phaseEnd;

  assign busActive = (phase != sPipeIdle) && (phase != sPipeInvalid);
  assign grantB    = iReqValidB && (!iReqValidA || !lastGrantB);
  assign grantA    = iReqValidA && !grantB;
  assign accept    = (phase == sPipeIdle) && !iReset && (iReqValidA || iReqValidB);
  assign winSel    = grantB ? iReqSelectB : iReqSelectA;

  assign oReqReadyA = accept && grantA;
  assign oReqReadyB = accept && grantB;

  sysx_bus_clockgen #(.CLOCK_DIV(CLOCK_DIV)) uClockgen (
    .iClock      (iClock),
    .iReset      (iReset),
    .iActive     (busActive),
    .oPhaseStart (phaseStart),
    .oSample     (sample),
    .oPhaseEnd   (phaseEnd),
    .oBusClock   (oBusClock)
  );

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) phase <= sPipeIdle;
    else        phase <= nextPhase;
  end

  always_comb begin
    nextPhase = phase;
    case (phase)
      sPipeIdle:
        if (accept && winSel != SYSX_SELECT_NONE) nextPhase = sPipeBegin;
      sPipeBegin, sPipeLowLow, sPipeLow, sPipeHigh, sPipeHighHigh:
        if (phaseEnd) nextPhase = pipePhase_t'(phase + 3'd1);
      sPipeEnd:
        if (phaseEnd) nextPhase = sPipeIdle;
      default:
        nextPhase = sPipeIdle;
    endcase
  end

`ifdef SYSX_SCHED_STATUS_EN
  logic [7:0] statusByte, endStatus;
  // With CLOCK_DIV=1 the End sample and End completion share a cycle.
  assign endStatus = sample ? iBusMISO : statusByte;
`endif

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      lastGrantB <= 1'b1;
      curId      <= 1'b0;
      curSel     <= SYSX_SELECT_NONE;
      curCmd     <= 8'h00;
      curData    <= '0;
      collected  <= '0;
      oRespValid <= 1'b0;
      oRespId    <= 1'b0;
      oRespData  <= '0;
      oRespError <= 1'b0;
`ifdef SYSX_SCHED_STATUS_EN
      statusByte <= SYSX_STATUS_OK;
`endif
    end else begin
      oRespValid <= 1'b0;
      if (accept) begin
        lastGrantB <= grantB;
        curId      <= grantB;
        curSel     <= winSel;
        curCmd     <= grantB ? iReqCmdB : iReqCmdA;
        curData    <= grantB ? iReqDataB : iReqDataA;
        if (winSel == SYSX_SELECT_NONE) begin
          oRespValid <= 1'b1;
          oRespId    <= grantB;
          oRespData  <= '0;
          oRespError <= 1'b1;
        end
      end
      if (phaseStart && phase == sPipeBegin) collected <= '0;
      if (sample && isDataPhase(phase)) collected[laneBase(phase) +: 8] <= iBusMISO;
`ifdef SYSX_SCHED_STATUS_EN
      if (sample && phase == sPipeEnd) statusByte <= iBusMISO;
`endif
      if (phaseEnd && phase == sPipeEnd) begin
        oRespValid <= 1'b1;
        oRespId    <= curId;
        oRespData  <= collected;
`ifdef SYSX_SCHED_STATUS_EN
        oRespError <= (endStatus != SYSX_STATUS_OK);
`else
        oRespError <= 1'b0;
`endif
      end
    end
  end

  always_comb begin
    oBusMOSI = 8'h00;
    case (phase)
      sPipeBegin:                                     oBusMOSI = curCmd;
      sPipeLowLow, sPipeLow, sPipeHigh, sPipeHighHigh: oBusMOSI = curData[laneBase(phase) +: 8];
      default:                                        oBusMOSI = 8'h00;
    endcase
  end

  assign oBusSelect = busActive ? curSel : SYSX_SELECT_NONE;

endmodule

// File: tb/tb_sysx_pipe_scheduler.sv
// tb/tb_sysx_pipe_scheduler.sv - self-checking bench for sysx_pipe_scheduler
module tb_sysx_pipe_scheduler;

  localparam int CD = 2;

  int checks = 0;
  int errors = 0;
  bit lastB  = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        vA = 0, vB = 0;
  logic [1:0]  selA = 0, selB = 0;
  logic [7:0]  cmdA = 0, cmdB = 0;
  logic [31:0] dataA = 0, dataB = 0;
  logic        readyA, readyB, respValid, respId, respError;
  logic [31:0] respData;
  logic [7:0]  mosi;
  logic [7:0]  miso = 0;
  logic        busClk;
  logic [1:0]  busSel;

  logic        c1VA = 0, c1VB = 0;
  logic [1:0]  c1SelA = 0, c1SelB = 0;
  logic [7:0]  c1CmdA = 0, c1CmdB = 0;
  logic [31:0] c1DataA = 0, c1DataB = 0;
  logic        c1ReadyA, c1ReadyB, c1RespValid, c1RespId, c1RespError;
  logic [31:0] c1RespData;
  logic [7:0]  c1Mosi;
  logic [7:0]  c1Miso = 0;
  logic        c1BusClk;
  logic [1:0]  c1BusSel;

  always #5 clk = ~clk;

  sysx_pipe_scheduler #(.CLOCK_DIV(CD)) dut (
    .iClock(clk), .iReset(rst),
    .iReqValidA(vA), .iReqSelectA(selA), .iReqCmdA(cmdA), .iReqDataA(dataA), .oReqReadyA(readyA),
    .iReqValidB(vB), .iReqSelectB(selB), .iReqCmdB(cmdB), .iReqDataB(dataB), .oReqReadyB(readyB),
    .oRespValid(respValid), .oRespId(respId), .oRespData(respData), .oRespError(respError),
    .oBusMOSI(mosi), .iBusMISO(miso), .oBusClock(busClk), .oBusSelect(busSel)
  );

  sysx_pipe_scheduler #(.CLOCK_DIV(1)) dut1 (
    .iClock(clk), .iReset(rst),
    .iReqValidA(c1VA), .iReqSelectA(c1SelA), .iReqCmdA(c1CmdA), .iReqDataA(c1DataA), .oReqReadyA(c1ReadyA),
    .iReqValidB(c1VB), .iReqSelectB(c1SelB), .iReqCmdB(c1CmdB), .iReqDataB(c1DataB), .oReqReadyB(c1ReadyB),
    .oRespValid(c1RespValid), .oRespId(c1RespId), .oRespData(c1RespData), .oRespError(c1RespError),
    .oBusMOSI(c1Mosi), .iBusMISO(c1Miso), .oBusClock(c1BusClk), .oBusSelect(c1BusSel)
  );

  // Follows one accepted transfer from cycle T+1 through its response cycle.
  task automatic follow(input bit id, input logic [1:0] sel, input logic [7:0] cmd,
                        input logic [31:0] data, input logic [31:0] misoWord,
                        input logic [7:0] status, input bit junk);
    int n, p, o;
    logic [7:0] expMosi;
    logic [1:0] expSel;
    logic expClk, expErr;
    logic [31:0] expData;
    n = (sel == 2'd0) ? 0 : 12 * CD;
    expData = (sel == 2'd0) ? 32'h0 : misoWord;
`ifdef SYSX_SCHED_STATUS_EN
    expErr = (sel == 2'd0) || (status != 8'h00);
`else
    expErr = (sel == 2'd0);
`endif
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      p = (k - 1) / (2 * CD);
      o = (k - 1) % (2 * CD);
      if (k <= n) begin
        expSel  = sel;
        expClk  = (o >= CD);
        expMosi = (p == 0) ? cmd : (p == 5) ? 8'h00 : 8'(data >> (8 * (p - 1)));
      end else begin
        expSel = 2'd0; expClk = 1'b0; expMosi = 8'h00;
      end
      checks++; if (busSel !== expSel) begin errors++; $display("FAIL bus_select k=%0d: got %0d want %0d", k, busSel, expSel); end
      checks++; if (busClk !== expClk) begin errors++; $display("FAIL bus_clock k=%0d: got %0b want %0b", k, busClk, expClk); end
      checks++; if (mosi !== expMosi) begin errors++; $display("FAIL mosi k=%0d: got %h want %h", k, mosi, expMosi); end
      checks++; if (respValid !== (k == n + 1)) begin errors++; $display("FAIL resp_valid k=%0d: got %0b want %0b", k, respValid, k == n + 1); end
      if (k == n + 1) begin
        checks++; if (respId !== id) begin errors++; $display("FAIL resp_id: got %0b want %0b", respId, id); end
        checks++; if (respData !== expData) begin errors++; $display("FAIL resp_data: got %h want %h", respData, expData); end
        checks++; if (respError !== expErr) begin errors++; $display("FAIL resp_error: got %0b want %0b", respError, expErr); end
      end
      if (k == 1) begin
        if (id) vB = 1'b0; else vA = 1'b0;
      end
      if (k <= n) begin
        if (o == CD) miso = (p == 0) ? 8'($urandom) : (p == 5) ? status : 8'(misoWord >> (8 * (p - 1)));
        else         miso = 8'($urandom);
        if (junk) begin vA = 1'($urandom); vB = 1'($urandom); end
        #1;
        checks++; if ({readyA, readyB} !== 2'b00) begin errors++; $display("FAIL busy_ready k=%0d: got %b want 00", k, {readyA, readyB}); end
      end else begin
        miso = 8'h00;
        if (junk) begin vA = 1'b0; vB = 1'b0; end
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    lastB = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({readyA, readyB, respValid, respId, respError} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {readyA, readyB, respValid, respId, respError}); end
    checks++; if (respData !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", respData); end
    checks++; if ({mosi, busClk, busSel} !== 11'b0) begin errors++; $display("FAIL reset_bus: got %h want 0", {mosi, busClk, busSel}); end
    checks++; if ({c1BusSel, c1BusClk, c1RespValid} !== 4'b0) begin errors++; $display("FAIL reset_dut1: got %b want 0000", {c1BusSel, c1BusClk, c1RespValid}); end
    rst = 1'b0;
    lastB = 1'b1;
    @(negedge clk);
    checks++; if (busSel !== 2'd0) begin errors++; $display("FAIL idle_select: got %0d want 0", busSel); end
  endtask

  task automatic test_single();
    @(negedge clk);
    vA = 1'b1; selA = 2'd2; cmdA = 8'h3C; dataA = 32'h11223344;
    #1;
    checks++; if ({readyA, readyB} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {readyA, readyB}); end
    lastB = 1'b0;
    follow(1'b0, 2'd2, 8'h3C, 32'h11223344, 32'hDDCCBBAA, 8'h00, 1'b0);
  endtask

  task automatic test_arbitration();
    logic [31:0] w;
    doReset();
    @(negedge clk);
    vA = 1'b1; selA = 2'd1; cmdA = 8'hA1; dataA = $urandom;
    vB = 1'b1; selB = 2'd3; cmdB = 8'hB2; dataB = $urandom;
    #1;
    checks++; if ({readyA, readyB} !== 2'b10) begin errors++; $display("FAIL arb_first: got %b want 10", {readyA, readyB}); end
    lastB = 1'b0;
    w = $urandom;
    follow(1'b0, selA, cmdA, dataA, w, 8'h00, 1'b0);
    #1;
    checks++; if ({readyA, readyB} !== 2'b01) begin errors++; $display("FAIL arb_back_to_back: got %b want 01", {readyA, readyB}); end
    lastB = 1'b1;
    w = $urandom;
    follow(1'b1, selB, cmdB, dataB, w, 8'h00, 1'b0);
    vA = 1'b1; vB = 1'b1; dataA = $urandom; cmdA = 8'hC3;
    #1;
    checks++; if ({readyA, readyB} !== 2'b10) begin errors++; $display("FAIL arb_second_pair: got %b want 10", {readyA, readyB}); end
    lastB = 1'b0;
    w = $urandom;
    follow(1'b0, selA, cmdA, dataA, w, 8'h00, 1'b0);
    vB = 1'b0;
  endtask

  task automatic test_invalid_select();
    @(negedge clk);
    vB = 1'b1; selB = 2'd0; cmdB = 8'h77; dataB = 32'hFFFF0000;
    #1;
    checks++; if ({readyA, readyB} !== 2'b01) begin errors++; $display("FAIL invsel_ready: got %b want 01", {readyA, readyB}); end
    lastB = 1'b1;
    follow(1'b1, 2'd0, cmdB, dataB, 32'h0, 8'h00, 1'b0);
    @(negedge clk);
    checks++; if (busSel !== 2'd0) begin errors++; $display("FAIL invsel_select_after: got %0d want 0", busSel); end
  endtask

  task automatic test_status();
    @(negedge clk);
    vA = 1'b1; selA = 2'd3; cmdA = 8'h5E; dataA = $urandom;
    #1;
    checks++; if ({readyA, readyB} !== 2'b10) begin errors++; $display("FAIL status_ready: got %b want 10", {readyA, readyB}); end
    lastB = 1'b0;
    follow(1'b0, 2'd3, cmdA, dataA, 32'h0BADF00D, 8'h05, 1'b0);
  endtask

  task automatic test_reset_midflight();
    int pulses;
    @(negedge clk);
    vA = 1'b1; selA = 2'd1; cmdA = 8'h5A; dataA = 32'hC0FFEE11;
    #1;
    checks++; if ({readyA, readyB} !== 2'b10) begin errors++; $display("FAIL midrst_ready: got %b want 10", {readyA, readyB}); end
    for (int k = 1; k <= 3 * 2 * CD + 1 + CD; k++) begin
      @(negedge clk);
      if (k == 1) vA = 1'b0;
      miso = 8'($urandom);
    end
    checks++; if ({busSel, busClk, mosi} !== {2'd1, 1'b1, 8'hFF}) begin errors++; $display("FAIL midrst_pre: got %h want %h", {busSel, busClk, mosi}, {2'd1, 1'b1, 8'hFF}); end
    rst = 1'b1;
    #1;
    checks++; if ({busSel, busClk, mosi, respValid} !== 12'h0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", {busSel, busClk, mosi, respValid}); end
    lastB = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12 * CD + 4; k++) begin
      @(negedge clk);
      if (respValid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_resp: got %0d pulses want 0", pulses); end
    vA = 1'b1; selA = 2'd2; cmdA = 8'h42; dataA = $urandom;
    #1;
    checks++; if ({readyA, readyB} !== 2'b10) begin errors++; $display("FAIL midrst_next_ready: got %b want 10", {readyA, readyB}); end
    lastB = 1'b0;
    follow(1'b0, 2'd2, cmdA, dataA, 32'h600DCAFE, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] pat;
    bit winB;
    logic [31:0] w;
    logic [7:0] st;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pat = 2'($urandom_range(1, 3));
      vA = pat[0]; vB = pat[1];
      selA = 2'($urandom); selB = 2'($urandom);
      cmdA = 8'($urandom); cmdB = 8'($urandom);
      dataA = $urandom; dataB = $urandom;
      w = $urandom;
      st = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      winB = vB && (!vA || !lastB);
      #1;
      checks++; if ({readyA, readyB} !== {!winB, winB}) begin errors++; $display("FAIL rand_ready i=%0d: got %b want %b", i, {readyA, readyB}, {!winB, winB}); end
      lastB = winB;
      follow(winB, winB ? selB : selA, winB ? cmdB : cmdA, winB ? dataB : dataA, w, st, 1'b1);
    end
  endtask

  task automatic test_clockdiv1();
    int p, o;
    logic [31:0] w;
    logic [7:0] expMosi;
    @(negedge clk);
    c1VA = 1'b1; c1SelA = 2'd1; c1CmdA = 8'h81; c1DataA = $urandom;
    w = $urandom;
    #1;
    checks++; if (c1ReadyA !== 1'b1) begin errors++; $display("FAIL cd1_ready: got %0b want 1", c1ReadyA); end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) c1VA = 1'b0;
      p = (k - 1) / 2;
      o = (k - 1) % 2;
      expMosi = (k > 12 || p == 5) ? 8'h00 : (p == 0) ? c1CmdA : 8'(c1DataA >> (8 * (p - 1)));
      checks++; if (c1BusClk !== (k <= 12 && o == 1)) begin errors++; $display("FAIL cd1_clock k=%0d: got %0b want %0b", k, c1BusClk, k <= 12 && o == 1); end
      checks++; if (c1BusSel !== ((k <= 12) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL cd1_select k=%0d: got %0d", k, c1BusSel); end
      checks++; if (c1Mosi !== expMosi) begin errors++; $display("FAIL cd1_mosi k=%0d: got %h want %h", k, c1Mosi, expMosi); end
      checks++; if (c1RespValid !== (k == 13)) begin errors++; $display("FAIL cd1_resp_valid k=%0d: got %0b want %0b", k, c1RespValid, k == 13); end
      if (k <= 12) c1Miso = (p >= 1 && p <= 4) ? 8'(w >> (8 * (p - 1))) : 8'h00;
      else         c1Miso = 8'h00;
      if (k == 13) begin
        checks++; if (c1RespData !== w) begin errors++; $display("FAIL cd1_data: got %h want %h", c1RespData, w); end
        checks++; if ({c1RespError, c1RespId} !== 2'b00) begin errors++; $display("FAIL cd1_err_id: got %b want 00", {c1RespError, c1RespId}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_invalid_select();
    test_status();
    test_reset_midflight();
    test_random();
    test_clockdiv1();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysx_pipe_scheduler.md
Name: sysx_pipe_scheduler

Overview:
- Shares the sysX peripheral bus between two requesters (A = CPU bridge, B = DMA) with round-robin arbitration.
- Sequences each granted request through the sysX pipe phases: Begin, LowLow, Low, High, HighHigh, End.
- Generates oBusClock and oBusSelect, serialises a 32-bit word onto the 8-bit MOSI bus, and collects the 32-bit MISO word.
- Sits between the CPU/DMA fabric and the sysX slot connector.

Parameters:
- CLOCK_DIV, 2: system clocks per oBusClock half-period; must be ≥1.

Ports:
- iClock  in  1  system clock.
- iReset  in  1  asynchronous reset, active-high.
- iReqValidA  in  1  requester A has a transfer pending; held until accepted.
- iReqSelectA  in  2  target slot; 0 is invalid, 1-3 are slots.
- iReqCmdA  in  8  command byte driven in the Begin phase.
- iReqDataA  in  32  write word; bit 0 is the MSB.
- oReqReadyA  out  1  one-cycle accept pulse.
- iReqValidB, iReqSelectB, iReqCmdB, iReqDataB, oReqReadyB: same as A, for requester B.
- oRespValid  out  1  one-cycle response pulse.
- oRespId  out  1  0 = A, 1 = B.
- oRespData  out  32  collected MISO word.
- oRespError  out  1  transfer failed.
- oBusMOSI  out  8  byte to slave.
- iBusMISO  in  8  byte from slave.
- oBusClock  out  1  bus clock.
- oBusSelect  out  2  active slot; 0 = none.

Behaviour:
- Reset values: all outputs 0, phase = sPipeIdle, last-grant = B. Reset mid-transfer aborts immediately: select drops to 0 and no response is issued.
- Arbitration runs only in Idle.
  - Grant the single valid requester.
  - If both are valid, grant the requester not granted last.
  - Accept cycle T: oReqReady of the winner = 1; select, cmd and data are captured; last-grant is updated. The loser sees no ready.
- Invalid select (0):
  - No bus activity.
  - At T+1: oRespValid=1, oRespError=1, oRespData=0.
  - Return to Idle at T+1; a new grant is possible at T+1.
- Valid select:
  - Phases run Begin→LowLow→Low→High→HighHigh→End→Idle. Each phase lasts 2*CLOCK_DIV cycles.
  - oBusSelect = captured select from the start of Begin through the end of End.
  - oBusClock is low for the first CLOCK_DIV cycles of each phase and high for the last CLOCK_DIV.
  - oBusMOSI changes only at phase start: Begin = cmd, LowLow = data[24:31], Low = data[16:23], High = data[8:15], HighHigh = data[0:7], End = 8'h00.
- MISO sampling:
  - iBusMISO is sampled in the cycle oBusClock rises (phase offset CLOCK_DIV).
  - LowLow→resp[24:31], Low→[16:23], High→[8:15], HighHigh→[0:7].
  - Begin and End samples are not stored in data.
- Response timing: oRespValid pulses in cycle T+1+12*CLOCK_DIV, with oRespId = granted requester. Idle resumes the same cycle, so a back-to-back grant is possible in that cycle.
- No response backpressure.
- Dropping iReqValid before acceptance is legal. Request inputs are ignored while busy.
- sPipeInvalid is unreachable. If entered, the block goes to Idle with select 0.

Optional Feature:
- SYSX_SCHED_STATUS_EN defined:
  - End-phase MISO sample is the slave status byte.
  - Nonzero status → oRespError=1; oRespData still reports the collected word.
- Not defined: End sample is ignored; oRespError is set only for select 0.

Decomposition:
- Package sysx_pkg holds:
  - Pipe phase encoding: Idle 0, Begin 1, LowLow 2, Low 3, High 4, HighHigh 5, End 6, Invalid 7.
  - Byte-lane mapping per phase.
  - SYSX_STATUS_OK = 8'h00.
  - SYSX_SELECT_NONE = 2'd0.
- Sub-module sysx_bus_clockgen: counter producing phase-start strobe, sample strobe, phase-end strobe and oBusClock level from CLOCK_DIV. It is reset to count 0 on Idle.

Test Plan:
- A only, select 2, cmd 8'h3C, data 32'h11223344, CLOCK_DIV=2:
  - MOSI sequence 3C,44,33,22,11,00.
  - Slave MISO AA,BB,CC,DD → oRespData 32'hDDCCBBAA.
  - oRespValid at T+25, Id 0, Error 0.
- A and B valid together from reset:
  - A granted first, B granted in A's response cycle.
  - A second simultaneous pair after that grants A again: last-grant = B.
- Select 0 from B → ready at T, response at T+1 with Error 1, Data 0, oBusSelect stays 0.
- Reset asserted during High phase → oBusSelect, oBusClock and MOSI go to 0 immediately; no oRespValid. The next request completes normally.
- SYSX_SCHED_STATUS_EN defined, End MISO 8'h05 → Error 1, data intact. Without the macro → Error 0.
- CLOCK_DIV=1 → each phase is 2 cycles and the response arrives at T+13.
